sram_dram_responder: RTL

Memory-side responder for the MCU's external DRAM request port: accepts single-word read/write requests (`dram_mem_*`) and returns `dram_ack` plus read data. Each 32-bit request is served by one or two 16-bit accesses to an external asynchronous SRAM, with a programmable number of wait states. The block sits at board level between the MCU top and the SRAM pins.

---
 rtl/sram_dram_responder_pkg.sv | 37 +++
 rtl/sram_dram_responder_half_access.sv | 100 ++++++++++
 rtl/sram_dram_responder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sram_dram_responder_pkg.sv
// Shared types and constants for the SRAM-backed DRAM responder.
package sram_dram_responder_pkg;

    localparam int MEM_ADDR_BITS  = 19;
    localparam int SRAM_DATA_BITS = 16;
    localparam int SRAM_WAIT_BITS = 4;

    typedef enum logic [2:0] {
        SRAM_ST_IDLE,
        SRAM_ST_SETUP,
        SRAM_ST_STROBE,
        SRAM_ST_HOLD,
        SRAM_ST_ACK
    } sram_state_e;

    // Top-level sequencer: a half access is either running in the sub-module or not.
    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_ACK
    } seq_state_e;

    typedef struct packed {
        logic                     write;
        logic [MEM_ADDR_BITS-1:0] addr;
        logic [3:0]               be;
        logic [31:0]              wdata;
    } sram_req_t;

    // Returns {ub_n, lb_n} for one halfword; reads always enable both lanes.
    function automatic logic [1:0] half_lanes_n(input logic write, input logic [3:0] be,
                                                input logic half);
        if (!write) return 2'b00;
        return half ? ~be[3:2] : ~be[1:0];
    endfunction

endpackage

// File: rtl/sram_dram_responder_half_access.sv
// One SETUP / STROBE / HOLD sequence for a single SRAM halfword; all pin outputs registered.
module sram_half_access
    import sram_dram_responder_pkg::*;
#(
    parameter int ADDR_BITS   = 20,
    parameter int WAIT_STATES = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      sync_reset,
    input  logic                      start,
    input  logic                      write,
    input  logic [ADDR_BITS-1:0]      addr,
    input  logic [1:0]                lanes_n,
    input  logic [SRAM_DATA_BITS-1:0] wdata,
    output logic                      sample,
    output logic                      done,
    output logic [ADDR_BITS-1:0]      sram_addr,
    output logic [SRAM_DATA_BITS-1:0] sram_dq_out,
    output logic                      sram_dq_oe,
    output logic                      sram_ce_n,
    output logic                      sram_oe_n,
    output logic                      sram_we_n,
    output logic                      sram_lb_n,
    output logic                      sram_ub_n
);

    sram_state_e               state;
    logic [SRAM_WAIT_BITS-1:0] cnt;
    logic                      wr;

    assign done   = (state == SRAM_ST_HOLD);
    assign sample = (state == SRAM_ST_STROBE) && (cnt == '0) && !wr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SRAM_ST_IDLE;
            cnt         <= '0;
            wr          <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
            sram_ub_n   <= 1'b1;
        end else if (sync_reset) begin
            state       <= SRAM_ST_IDLE;
            cnt         <= '0;
            wr          <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
            sram_ub_n   <= 1'b1;
        end else begin
            case (state)
                // HOLD can chain straight into the next half's SETUP
                SRAM_ST_IDLE, SRAM_ST_HOLD: begin
                    if (start) begin
                        state                  <= SRAM_ST_SETUP;
                        wr                     <= write;
                        sram_addr              <= addr;
                        sram_ce_n              <= 1'b0;
                        {sram_ub_n, sram_lb_n} <= lanes_n;
                        sram_dq_oe             <= write;
                        if (write) sram_dq_out <= wdata;
                    end else begin
                        state      <= SRAM_ST_IDLE;
                        sram_ce_n  <= 1'b1;
                        sram_lb_n  <= 1'b1;
                        sram_ub_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                    end
                end
                SRAM_ST_SETUP: begin
                    state <= SRAM_ST_STROBE;
                    cnt   <= SRAM_WAIT_BITS'(WAIT_STATES);
                    if (wr) sram_we_n <= 1'b0;
                    else    sram_oe_n <= 1'b0;
                end
                SRAM_ST_STROBE: begin
                    if (cnt == '0) begin
                        state     <= SRAM_ST_HOLD;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= SRAM_ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sram_dram_responder.sv
// 32-bit request port served by one or two 16-bit async SRAM accesses.
// SRAM_HALF_SKIP_EN: when defined, write halves with no enabled bytes are skipped.
module sram_dram_responder
    import sram_dram_responder_pkg::*;
#(
    parameter int SRAM_ADDR_BITS = 20,
    parameter int WAIT_STATES    = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      sync_reset,
    input  logic [MEM_ADDR_BITS-1:0]  mem_addr,
    input  logic                      mem_read_en,
    input  logic                      mem_write_en,
    input  logic [3:0]                mem_byte_enable,
    input  logic [31:0]               mem_write_data,
    output logic                      mem_ack,
    output logic [31:0]               mem_read_data,
    output logic                      busy,
    output logic [SRAM_ADDR_BITS-1:0] sram_addr,
    input  logic [SRAM_DATA_BITS-1:0] sram_dq_in,
    output logic [SRAM_DATA_BITS-1:0] sram_dq_out,
    output logic                      sram_dq_oe,
    output logic                      sram_ce_n,
    output logic                      sram_oe_n,
    output logic                      sram_we_n,
    output logic                      sram_lb_n,
    output logic                      sram_ub_n
);

    seq_state_e seq;
    sram_req_t  req, cur;
    logic       half;
    logic [31:0] rd_buf;
    logic       accept, start, start_half, go_ack, h0_en, h1_en;
    logic       sample, done;

    // In IDLE the live request drives the first half directly so SETUP starts on the next cycle.
    always_comb begin
        cur = req;
        if (seq == SEQ_IDLE) begin
            cur.write = mem_write_en;
            cur.addr  = mem_addr;
            cur.be    = mem_byte_enable;
            cur.wdata = mem_write_data;
        end
        accept = (seq == SEQ_IDLE) && (mem_read_en || mem_write_en);
`ifdef SRAM_HALF_SKIP_EN
        h0_en = !cur.write || (cur.be[1:0] != 2'b00);
        h1_en = !cur.write || (cur.be[3:2] != 2'b00);
`else
        h0_en = 1'b1;
        h1_en = 1'b1;
`endif
        start      = 1'b0;
        start_half = 1'b0;
        go_ack     = 1'b0;
        if (accept) begin
            if (h0_en) begin
                start = 1'b1;
            end else if (h1_en) begin
                start      = 1'b1;
                start_half = 1'b1;
            end else begin
                go_ack = 1'b1;
            end
        end else if (seq == SEQ_RUN && done) begin
            if (!half && h1_en) begin
                start      = 1'b1;
                start_half = 1'b1;
            end else begin
                go_ack = 1'b1;
            end
        end
    end

    sram_half_access #(
        .ADDR_BITS  (SRAM_ADDR_BITS),
        .WAIT_STATES(WAIT_STATES)
    ) u_half (
        .clk        (clk),
        .reset_n    (reset_n),
        .sync_reset (sync_reset),
        .start      (start),
        .write      (cur.write),
        .addr       (SRAM_ADDR_BITS'({cur.addr, start_half})),
        .lanes_n    (half_lanes_n(cur.write, cur.be, start_half)),
        .wdata      (start_half ? cur.wdata[31:16] : cur.wdata[15:0]),
        .sample     (sample),
        .done       (done),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_lb_n  (sram_lb_n),
        .sram_ub_n  (sram_ub_n)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq           <= SEQ_IDLE;
            req           <= '0;
            half          <= 1'b0;
            rd_buf        <= '0;
            mem_read_data <= '0;
            mem_ack       <= 1'b0;
            busy          <= 1'b0;
        end else if (sync_reset) begin
            seq           <= SEQ_IDLE;
            req           <= '0;
            half          <= 1'b0;
            rd_buf        <= '0;
            mem_read_data <= '0;
            mem_ack       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            mem_ack <= 1'b0;
            if (sample) begin
                if (half) rd_buf[31:16] <= sram_dq_in;
                else      rd_buf[15:0]  <= sram_dq_in;
            end
            case (seq)
                SEQ_IDLE: begin
                    if (accept) begin
                        req     <= cur;
                        half    <= start_half;
                        busy    <= 1'b1;
                        seq     <= go_ack ? SEQ_ACK : SEQ_RUN;
                        mem_ack <= go_ack;
                    end
                end
                SEQ_RUN: begin
                    if (go_ack) begin
                        seq     <= SEQ_ACK;
                        mem_ack <= 1'b1;
                        if (!req.write) mem_read_data <= rd_buf;
                    end else if (start) begin
                        half <= 1'b1;
                    end
                end
                SEQ_ACK: begin
                    seq  <= SEQ_IDLE;
                    busy <= 1'b0;
                end
                default: seq <= SEQ_IDLE;
            endcase
        end
    end

endmodule
